// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch port and the
// load/store port. Serves one access at a time with round-robin tie-breaking,
// and answers misaligned or unacknowledged accesses with ERR_DATA.
module mem_port_arbiter #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 16,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err
);

  localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    ERR_RESP = 2'd2
  } stateT;

  stateT             state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic              lastData, lastDataNext;   // 1: data port won the last grant
  logic              selData, selDataNext;     // requester owning the access in flight

  logic              ifGntNext, dGntNext, ifRvalidNext, dRvalidNext;
  logic [DATA_W-1:0] ifRdataNext, dRdataNext;
  logic              memReqNext, memWeNext;
  logic [ADDR_W-1:0] memAddrNext;
  logic [DATA_W-1:0] memWdataNext;
  logic              errNext;

  logic              pickData;
  logic [ADDR_W-1:0] pickAddr;
  logic              respond;
  logic [DATA_W-1:0] respData;

  // Next-state and next-output logic: arbitration, memory handshake, timeout.
  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    lastDataNext = lastData;
    selDataNext  = selData;
    ifGntNext    = 1'b0;
    dGntNext     = 1'b0;
    ifRvalidNext = 1'b0;
    dRvalidNext  = 1'b0;
    ifRdataNext  = if_rdata;
    dRdataNext   = d_rdata;
    memReqNext   = mem_req;
    memWeNext    = mem_we;
    memAddrNext  = mem_addr;
    memWdataNext = mem_wdata;
    errNext      = err;
    pickData     = 1'b0;
    pickAddr     = '0;
    respond      = 1'b0;
    respData     = '0;

    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          // Lone requester wins; on a tie the port not granted last wins.
          pickData     = d_req && (!if_req || !lastData);
          pickAddr     = pickData ? d_addr : if_addr;
          selDataNext  = pickData;
          lastDataNext = pickData;
          ifGntNext    = !pickData;
          dGntNext     = pickData;
          if (pickAddr[1:0] != 2'b00) begin
            stateNext = ERR_RESP;
            errNext   = 1'b1;
          end else begin
            stateNext    = ACCESS;
            cntNext      = '0;
            memReqNext   = 1'b1;
            memWeNext    = pickData && d_we;
            memAddrNext  = pickAddr;
            memWdataNext = pickData ? d_wdata : '0;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          memReqNext = 1'b0;
          memWeNext  = 1'b0;
          respond    = 1'b1;
          respData   = (selData && mem_we) ? '0 : mem_rdata;
          stateNext  = IDLE;
        end else if (cnt == CNT_LAST) begin
          memReqNext = 1'b0;
          memWeNext  = 1'b0;
          respond    = 1'b1;
          respData   = ERR_DATA;
          errNext    = 1'b1;
          stateNext  = IDLE;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      ERR_RESP: begin
        respond   = 1'b1;
        respData  = ERR_DATA;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    // Route the response to whichever port owns the access.
    if (respond) begin
      if (selData) begin
        dRvalidNext = 1'b1;
        dRdataNext  = respData;
      end else begin
        ifRvalidNext = 1'b1;
        ifRdataNext  = respData;
      end
    end
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lastData  <= 1'b1;
      selData   <= 1'b0;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      lastData  <= lastDataNext;
      selData   <= selDataNext;
      if_gnt    <= ifGntNext;
      if_rvalid <= ifRvalidNext;
      if_rdata  <= ifRdataNext;
      d_gnt     <= dGntNext;
      d_rvalid  <= dRvalidNext;
      d_rdata   <= dRdataNext;
      mem_req   <= memReqNext;
      mem_we    <= memWeNext;
      mem_addr  <= memAddrNext;
      mem_wdata <= memWdataNext;
      busy      <= (stateNext != IDLE);
      err       <= errNext;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic
// from both ports against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int          ADDR_W   = 32;
  localparam int          DATA_W   = 32;
  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic              clk;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req, d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy, err;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running (got no finish, expected finish)");
    $fatal(1, "watchdog expired");
  end

  int nChecks = 0;
  int nErrors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int   ackDelay   = 1;   // cycles mem_req is high before ack; 0 = never ack
  bit   lateAck    = 1'b0;
  int   lastReqLen = 0;
  bit   errModel   = 1'b0;
  bit   idleModel  = 1'b1;
  bit   lastModelData = 1'b1;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h3000) return 32'h8C220004;
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit isErrResp(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (ackDelay == 0) || (ackDelay > TIMEOUT);
  endfunction

  function automatic logic [31:0] expRdata(input bit isData, input bit we, input logic [31:0] addr);
    if (isErrResp(addr)) return ERR_DATA;
    if (isData && we) return 32'h0;
    return memWord(addr);
  endfunction

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    a = $urandom & 32'h0000_FFFC;
    if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  // Memory responder: acks after ackDelay cycles of mem_req, checks the
  // request fields stay put, and can inject one stray ack while idle.
  initial begin
    int          reqCycles;
    logic [31:0] reqAddr;
    logic        reqWe;
    reqCycles = 0;
    reqAddr   = '0;
    reqWe     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (mem_req === 1'b1) begin
        reqCycles++;
        if (reqCycles == 1) begin
          reqAddr = mem_addr;
          reqWe   = mem_we;
        end else begin
          chk("memStable", {mem_we, mem_addr}, {reqWe, reqAddr});
        end
        if (ackDelay != 0 && reqCycles == ackDelay) begin
          mem_ack   = 1'b1;
          mem_rdata = memWord(mem_addr);
        end
      end else begin
        if (reqCycles != 0) lastReqLen = reqCycles;
        reqCycles = 0;
        if (lateAck) begin
          mem_ack   = 1'b1;
          mem_rdata = 32'h0BAD_0BAD;
          lateAck   = 1'b0;
        end
      end
    end
  end

  // Grant/busy monitor: predicts each grant from the round-robin rule and
  // tracks whether an access is outstanding.
  initial begin
    bit expIfG, expDG, pickD;
    expIfG = 1'b0;
    expDG  = 1'b0;
    forever begin
      @(posedge clk);
      expIfG = 1'b0;
      expDG  = 1'b0;
      if (rst_n !== 1'b1) begin
        idleModel     = 1'b1;
        lastModelData = 1'b1;
        errModel      = 1'b0;
      end else if (idleModel && (if_req || d_req)) begin
        pickD         = if_req ? (d_req && !lastModelData) : 1'b1;
        lastModelData = pickD;
        expIfG        = !pickD;
        expDG         = pickD;
        idleModel     = 1'b0;
      end
      #1;
      if (rst_n === 1'b1) begin
        chk("ifGnt", if_gnt, expIfG);
        chk("dGnt", d_gnt, expDG);
        if (if_rvalid || d_rvalid) begin
          chk("spuriousRvalid", idleModel, 1'b0);
          chk("rvalidExclusive", if_rvalid && d_rvalid, 1'b0);
          idleModel = 1'b1;
        end
        chk("busy", busy, !idleModel);
      end
    end
  end

  // One complete request/grant/response exchange on one port.
  task automatic issue(input bit isData, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, output int gntLat, output int rvLat);
    logic [31:0] exp;
    bit          seen, aligned, isErr;
    string       who;
    who     = isData ? "d" : "if";
    exp     = expRdata(isData, we, addr);
    isErr   = isErrResp(addr);
    aligned = (addr[1:0] == 2'b00);
    if (isData) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    gntLat = 0;
    seen   = 1'b0;
    while (!seen && gntLat < 200) begin
      @(negedge clk);
      gntLat++;
      seen = isData ? d_gnt : if_gnt;
    end
    if (isData) d_req = 1'b0; else if_req = 1'b0;
    rvLat = 0;
    if (!seen) begin
      chk($sformatf("%sGntTimeout", who), 1'b0, 1'b1);
      return;
    end
    chk($sformatf("%sGntMemReq", who), mem_req, aligned);
    if (aligned) begin
      chk($sformatf("%sMemAddr", who), mem_addr, addr);
      chk($sformatf("%sMemWe", who), mem_we, isData && we);
      chk($sformatf("%sMemWdata", who), mem_wdata, isData ? wdata : 32'h0);
    end
    seen = 1'b0;
    while (!seen && rvLat < 200) begin
      @(negedge clk);
      rvLat++;
      seen = isData ? d_rvalid : if_rvalid;
    end
    if (!seen) begin
      chk($sformatf("%sRvalidTimeout", who), 1'b0, 1'b1);
      return;
    end
    chk($sformatf("%sRdata", who), isData ? d_rdata : if_rdata, exp);
    chk($sformatf("%sOtherRvalid", who), isData ? if_rvalid : d_rvalid, 1'b0);
    if (!aligned) chk($sformatf("%sMisalignNoMem", who), mem_req, 1'b0);
    if (isErr) errModel = 1'b1;
    chk($sformatf("%sErr", who), err, errModel);
  endtask

  initial begin
    int g, r, ga, ra, gb, rb;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstCtrl", {mem_req, mem_we, busy, err, if_gnt, if_rvalid, d_gnt, d_rvalid}, 8'h0);
    chk("rstData", {if_rdata, d_rdata}, 64'h0);
    chk("rstMem", {mem_addr, mem_wdata}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single fetch with a one-cycle memory
    ackDelay = 1;
    issue(1'b0, 1'b0, 32'h3000, 32'h0, g, r);
    chk("fetchGntLat", g, 1);
    chk("fetchRvLat", r, 1);
    chk("fetchDataPortQuiet", {d_gnt, d_rvalid, d_rdata}, 34'h0);

    // Both ports out of reset, each re-requesting at once: F, D, F, D, ...
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fork
      begin
        int gf, rf;
        for (int i = 0; i < 3; i++) begin
          issue(1'b0, 1'b0, 32'h0000_0400 + 32'(i * 4), 32'h0, gf, rf);
          if (i == 0) chk("tieFetchFirst", gf, 1);
        end
      end
      begin
        int gd, rd;
        for (int j = 0; j < 3; j++) begin
          issue(1'b1, 1'b1, 32'h100, 32'h55, gd, rd);
          if (j == 0) chk("tieDataSecond", gd, 3);
        end
      end
    join

    // Wait states
    ackDelay = 5;
    issue(1'b0, 1'b0, 32'h2000, 32'h0, g, r);
    chk("waitRvLat", r, 5);
    @(negedge clk);
    chk("waitReqLen", lastReqLen, 5);
    issue(1'b1, 1'b1, 32'h2004, 32'hCAFE_F00D, g, r);
    chk("waitStoreRvLat", r, 5);

    // Ack on the very last allowed cycle still completes normally
    ackDelay = TIMEOUT;
    issue(1'b1, 1'b0, 32'h2008, 32'h0, g, r);
    chk("lastCycleAckRvLat", r, TIMEOUT);

    // Timeout, then a stray late ack, then a normal access
    ackDelay = 0;
    issue(1'b1, 1'b0, 32'h0200, 32'h0, g, r);
    chk("timeoutRvLat", r, TIMEOUT);
    @(negedge clk);
    chk("timeoutReqLen", lastReqLen, TIMEOUT);
    lateAck = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lateAckIgnored", {if_rvalid, d_rvalid, mem_req}, 3'b000);
    end
    ackDelay = 1;
    issue(1'b0, 1'b0, 32'h3000, 32'h0, g, r);
    chk("afterTimeoutRvLat", r, 1);

    // Misaligned load
    issue(1'b1, 1'b0, 32'h0102, 32'h0, g, r);
    chk("misalignGntLat", g, 1);
    chk("misalignRvLat", r, 1);

    // Reset in the middle of an access
    ackDelay = 0;
    if_req = 1'b1; if_addr = 32'h4000;
    @(negedge clk);
    chk("midRstGnt", if_gnt, 1'b1);
    if_req = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midRstCtrl", {mem_req, mem_we, busy, err, if_gnt, if_rvalid, d_gnt, d_rvalid}, 8'h0);
    chk("midRstData", {if_rdata, d_rdata}, 64'h0);
    chk("midRstAddr", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midRstNoRvalid", {if_rvalid, d_rvalid, mem_req}, 3'b000);
    end
    ackDelay = 1;
    fork
      issue(1'b0, 1'b0, 32'h5000, 32'h0, ga, ra);
      issue(1'b1, 1'b0, 32'h5004, 32'h0, gb, rb);
    join
    chk("postRstFetchFirst", ga, 1);
    chk("postRstDataSecond", gb, 3);

    // Randomized traffic from both ports
    for (int b = 0; b < 8; b++) begin
      case ($urandom_range(0, 7))
        0:       ackDelay = 0;
        1:       ackDelay = TIMEOUT;
        default: ackDelay = $urandom_range(1, 4);
      endcase
      fork
        begin
          int g1, r1;
          for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(1'b0, 1'b0, randAddr(), 32'h0, g1, r1);
            chk("randIfGntBound", g1 <= TIMEOUT + 2, 1'b1);
            chk("randIfRvBound", (r1 >= 1) && (r1 <= TIMEOUT), 1'b1);
          end
        end
        begin
          int g2, r2;
          for (int j = 0; j < 6; j++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(1'b1, 1'($urandom_range(0, 1)), randAddr(), $urandom, g2, r2);
            chk("randDGntBound", g2 <= TIMEOUT + 2, 1'b1);
            chk("randDRvBound", (r2 >= 1) && (r2 <= TIMEOUT), 1'b1);
          end
        end
      join
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
